// File: rtl/ddr_rd_checker.sv
// rtl/ddr_rd_checker.sv - line-sweep read checker for the ddr2_mgr read port
// Optional first-mismatch capture ports under DDR_RD_CHK_CAPTURE_EN.
module ddr_rd_checker #(
   parameter int DATA_W = 32,
   parameter int ROW_W  = 13,
   parameter int COL_W  = 10,
   parameter int BANK_W = 2,
   parameter int LEN_W  = 10,
   parameter logic [DATA_W-1:0] PATTERN = 32'hFDCB8610,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          clr_status,
   input  logic                          cfg_mode,
   input  logic [ROW_W-1:0]              cfg_row_first,
   input  logic [ROW_W-1:0]              cfg_row_last,
   input  logic [LEN_W-1:0]              cfg_xfr_len,
   output logic                          rd_mem_req,
   output logic [ROW_W+COL_W+BANK_W-1:0] rd_mem_addr,
   output logic [LEN_W-1:0]              rd_xfr_len,
   input  logic                          rd_mem_grant,
   input  logic [DATA_W-1:0]             rd_data,
   input  logic                          rd_data_valid,
   output logic                          busy,
   output logic                          data_fault,
   output logic                          len_fault,
   output logic [CNT_W-1:0]              fault_cnt,
   output logic [CNT_W-1:0]              screen_cnt,
`ifdef DDR_RD_CHK_CAPTURE_EN
   output logic [ROW_W-1:0]              fail_row,
   output logic [LEN_W-1:0]              fail_idx,
   output logic [DATA_W-1:0]             fail_data,
`endif
   output logic                          screen_cnt_overrun
);

   typedef enum logic [1:0] {IDLE, WAIT_GRANT, PRE_XFR, DATA_XFR} state_t;

   state_t             state;
   logic [ROW_W-1:0]   row;
   logic [LEN_W:0]     word_cnt;
   logic               stop_pend;

   logic               word_chk;
   logic [DATA_W-1:0]  exp_word;
   logic               mismatch;
   logic               stray;
   logic               line_done;
   logic               stop_now;
   logic               at_end;
   logic               sweep_done;
   logic               short_long;
   logic [ROW_W-1:0]   next_row;
   logic [LEN_W-1:0]   len_start;

   assign word_chk   = rd_data_valid && (state == PRE_XFR || state == DATA_XFR);
   assign exp_word   = cfg_mode ? PATTERN + DATA_W'(word_cnt) : PATTERN;
   assign mismatch   = word_chk && (rd_data != exp_word);
   assign stray      = rd_data_valid && (state == IDLE || state == WAIT_GRANT);
   assign line_done  = (state == DATA_XFR) && !rd_data_valid;
   assign stop_now   = stop_pend || stop;
   // >= also covers first > last, where the sweep collapses to cfg_row_first
   assign at_end     = (row >= cfg_row_last);
   assign sweep_done = line_done && !stop_now && at_end;
   assign short_long = line_done && (word_cnt != {1'b0, rd_xfr_len});
   assign next_row   = at_end ? cfg_row_first : row + 1'b1;
   assign len_start  = (cfg_xfr_len == '0) ? LEN_W'(1) : cfg_xfr_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row         <= '0;
         word_cnt    <= '0;
         stop_pend   <= 1'b0;
         rd_mem_req  <= 1'b0;
         rd_mem_addr <= '0;
         rd_xfr_len  <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               stop_pend <= 1'b0;
               if (start && !stop) begin
                  row         <= cfg_row_first;
                  rd_xfr_len  <= len_start;
                  rd_mem_addr <= {cfg_row_first, {COL_W{1'b0}}, {BANK_W{1'b0}}};
                  rd_mem_req  <= 1'b1;
                  busy        <= 1'b1;
                  state       <= WAIT_GRANT;
               end
            end
            WAIT_GRANT: begin
               if (stop) stop_pend <= 1'b1;
               if (rd_mem_grant) begin
                  rd_mem_req <= 1'b0;
                  word_cnt   <= '0;
                  state      <= PRE_XFR;
               end
            end
            PRE_XFR: begin
               if (stop) stop_pend <= 1'b1;
               if (rd_data_valid) begin
                  word_cnt <= LEN_W'(1);
                  state    <= DATA_XFR;
               end
            end
            DATA_XFR: begin
               if (rd_data_valid) begin
                  if (stop) stop_pend <= 1'b1;
                  if (!(&word_cnt)) word_cnt <= word_cnt + 1'b1;
               end else if (stop_now) begin
                  stop_pend <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  row         <= next_row;
                  rd_mem_addr <= {next_row, {COL_W{1'b0}}, {BANK_W{1'b0}}};
                  rd_mem_req  <= 1'b1;
                  state       <= WAIT_GRANT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A fault on the same cycle as clr_status survives the clear
   always_ff @(posedge clk) begin
      if (rst) begin
         data_fault         <= 1'b0;
         len_fault          <= 1'b0;
         fault_cnt          <= '0;
         screen_cnt         <= '0;
         screen_cnt_overrun <= 1'b0;
      end else begin
         if (mismatch)        data_fault <= 1'b1;
         else if (clr_status) data_fault <= 1'b0;

         if (mismatch) begin
            if (clr_status)        fault_cnt <= CNT_W'(1);
            else if (!(&fault_cnt)) fault_cnt <= fault_cnt + 1'b1;
         end else if (clr_status) begin
            fault_cnt <= '0;
         end

         if (stray || short_long) len_fault <= 1'b1;
         else if (clr_status)     len_fault <= 1'b0;

         if (sweep_done)      screen_cnt <= (clr_status ? '0 : screen_cnt) + 1'b1;
         else if (clr_status) screen_cnt <= '0;

         if (sweep_done && !clr_status && (&screen_cnt)) screen_cnt_overrun <= 1'b1;
         else if (clr_status)                            screen_cnt_overrun <= 1'b0;
      end
   end

`ifdef DDR_RD_CHK_CAPTURE_EN
   logic cap_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_valid <= 1'b0;
         fail_row  <= '0;
         fail_idx  <= '0;
         fail_data <= '0;
      end else if (mismatch && (!cap_valid || clr_status)) begin
         cap_valid <= 1'b1;
         fail_row  <= row;
         fail_idx  <= word_cnt[LEN_W-1:0];
         fail_data <= rd_data;
      end else if (clr_status) begin
         cap_valid <= 1'b0;
         fail_row  <= '0;
         fail_idx  <= '0;
         fail_data <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_ddr_rd_checker.sv
// tb/tb_ddr_rd_checker.sv - self-checking bench for ddr_rd_checker
// Plays the ddr2_mgr read side; capture ports checked when DDR_RD_CHK_CAPTURE_EN is set.
module tb_ddr_rd_checker;
   localparam int DATA_W = 32;
   localparam int ROW_W  = 13;
   localparam int COL_W  = 10;
   localparam int BANK_W = 2;
   localparam int LEN_W  = 10;
   localparam int CNT_W  = 4;
   localparam int ADDR_W = ROW_W + COL_W + BANK_W;
   localparam logic [31:0] PAT = 32'hFDCB8610;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0, stop = 1'b0, clr_status = 1'b0, cfg_mode = 1'b0;
   logic [ROW_W-1:0]  cfg_row_first = '0, cfg_row_last = '0;
   logic [LEN_W-1:0]  cfg_xfr_len = '0;
   logic              rd_mem_req;
   logic [ADDR_W-1:0] rd_mem_addr;
   logic [LEN_W-1:0]  rd_xfr_len;
   logic              rd_mem_grant = 1'b0;
   logic [DATA_W-1:0] rd_data = '0;
   logic              rd_data_valid = 1'b0;
   logic              busy, data_fault, len_fault, screen_cnt_overrun;
   logic [CNT_W-1:0]  fault_cnt, screen_cnt;
`ifdef DDR_RD_CHK_CAPTURE_EN
   logic [ROW_W-1:0]  fail_row;
   logic [LEN_W-1:0]  fail_idx;
   logic [DATA_W-1:0] fail_data;
`endif

   ddr_rd_checker #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_status(clr_status),
      .cfg_mode(cfg_mode), .cfg_row_first(cfg_row_first), .cfg_row_last(cfg_row_last),
      .cfg_xfr_len(cfg_xfr_len), .rd_mem_req(rd_mem_req), .rd_mem_addr(rd_mem_addr),
      .rd_xfr_len(rd_xfr_len), .rd_mem_grant(rd_mem_grant), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .busy(busy), .data_fault(data_fault),
      .len_fault(len_fault), .fault_cnt(fault_cnt), .screen_cnt(screen_cnt),
`ifdef DDR_RD_CHK_CAPTURE_EN
      .fail_row(fail_row), .fail_idx(fail_idx), .fail_data(fail_data),
`endif
      .screen_cnt_overrun(screen_cnt_overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model of the observable state
   int m_row, m_first, m_last, m_len, m_mode;
   int m_fault_cnt, m_screen;
   bit m_df, m_lf, m_ovr;
   bit m_cap_v;
   int m_cap_row, m_cap_idx;
   logic [31:0] m_cap_data;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear;
      m_df = 0; m_lf = 0; m_ovr = 0; m_fault_cnt = 0; m_screen = 0;
      m_cap_v = 0; m_cap_row = 0; m_cap_idx = 0; m_cap_data = '0;
   endtask

   task automatic model_mismatch(input int idx, input logic [31:0] word);
      m_df = 1;
      if (m_fault_cnt < CNT_MAX) m_fault_cnt++;
      if (!m_cap_v) begin
         m_cap_v = 1; m_cap_row = m_row; m_cap_idx = idx; m_cap_data = word;
      end
   endtask

   task automatic chk_status(input string tag);
      chk({tag, ".data_fault"}, data_fault, m_df);
      chk({tag, ".len_fault"}, len_fault, m_lf);
      chk({tag, ".fault_cnt"}, fault_cnt, m_fault_cnt);
      chk({tag, ".screen_cnt"}, screen_cnt, m_screen);
      chk({tag, ".overrun"}, screen_cnt_overrun, m_ovr);
`ifdef DDR_RD_CHK_CAPTURE_EN
      chk({tag, ".fail_row"}, fail_row, m_cap_row);
      chk({tag, ".fail_idx"}, fail_idx, m_cap_idx);
      chk({tag, ".fail_data"}, fail_data, m_cap_data);
`endif
   endtask

   task automatic start_run(input int first, input int last, input int len, input int mode);
      cfg_row_first = ROW_W'(first);
      cfg_row_last  = ROW_W'(last);
      cfg_xfr_len   = LEN_W'(len);
      cfg_mode      = mode[0];
      m_first = first; m_last = last; m_mode = mode;
      m_row = first;
      m_len = (len == 0) ? 1 : len;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   // One request/grant/data line; mask bit i corrupts word i
   task automatic serve_line(input int nwords, input int mask, input int gdelay,
                             input bit do_stop, input bit clr0);
      int waitc = 0;
      logic [ADDR_W-1:0] ea;
      logic [31:0] word;
      while (!rd_mem_req && waitc < 40) begin
         tick;
         waitc++;
      end
      ea = ADDR_W'(m_row) << (COL_W + BANK_W);
      chk("req_up", rd_mem_req, 1);
      chk("addr", rd_mem_addr, ea);
      chk("xfr_len", rd_xfr_len, m_len);
      for (int i = 0; i < gdelay; i++) begin
         tick;
         chk("req_hold", rd_mem_req, 1);
         chk("addr_hold", rd_mem_addr, ea);
      end
      rd_mem_grant = 1'b1;
      tick;
      rd_mem_grant = 1'b0;
      chk("req_drop", rd_mem_req, 0);
      repeat ($urandom_range(0, 2)) tick;
      for (int i = 0; i < nwords; i++) begin
         word = (m_mode != 0) ? PAT + 32'(i) : PAT;
         if (mask[i]) word = word ^ ($urandom() | 32'h1);
         rd_data       = word;
         rd_data_valid = 1'b1;
         stop          = do_stop && (i == 0);
         clr_status    = clr0 && (i == 0);
         if (clr0 && i == 0) model_clear;
         tick;
         stop = 1'b0;
         clr_status = 1'b0;
         if (mask[i]) model_mismatch(i, word);
      end
      rd_data_valid = 1'b0;
      tick;
      if (nwords != m_len) m_lf = 1;
      if (!do_stop) begin
         if (m_row >= m_last) begin
            m_row = m_first;
            m_screen++;
            if (m_screen > CNT_MAX) begin
               m_screen = 0;
               m_ovr = 1;
            end
         end else begin
            m_row++;
         end
      end
      chk_status("line");
      chk("busy", busy, !do_stop);
      chk("req_next", rd_mem_req, !do_stop);
   endtask

   task automatic pulse_clr;
      clr_status = 1'b1;
      tick;
      clr_status = 1'b0;
      model_clear;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, nw, r, mask;
      model_clear;
      repeat (3) tick;
      chk("rst.req", rd_mem_req, 0);
      chk("rst.addr", rd_mem_addr, 0);
      chk("rst.xfr_len", rd_xfr_len, 0);
      chk("rst.busy", busy, 0);
      rst = 1'b0;
      tick;
      chk_status("rst");

      // clean sweep rows 0..2 then wrap and stop
      start_run(0, 2, 4, 0);
      for (int i = 0; i < 4; i++) serve_line(4, 0, 1, i == 3, 0);
      chk("sweep.screen", screen_cnt, 1);
      repeat (3) tick;
      chk("sweep.idle_req", rd_mem_req, 0);

      // incrementing pattern, clean then word 2 bad with 7-cycle grant delay
      start_run(3, 3, 4, 1);
      serve_line(4, 0, 0, 0, 0);
      serve_line(4, 32'h4, 7, 1, 0);
      chk("mode1.fault_cnt", fault_cnt, 1);

      // short line
      pulse_clr;
      start_run(10, 12, 8, 0);
      serve_line(7, 0, 2, 1, 0);
      chk("short.len_fault", len_fault, 1);

      // stray valid in IDLE
      pulse_clr;
      rd_data_valid = 1'b1;
      tick;
      rd_data_valid = 1'b0;
      m_lf = 1;
      tick;
      chk_status("stray");

      // clear coinciding with a mismatch
      start_run(1, 1, 3, 1);
      serve_line(3, 32'h1, 0, 1, 1);
      chk("clrfault.cnt", fault_cnt, 1);

      // stop alone and start+stop in IDLE
      stop = 1'b1;
      tick;
      stop = 1'b0;
      chk("stop_idle.busy", busy, 0);
      start = 1'b1; stop = 1'b1;
      tick;
      start = 1'b0; stop = 1'b0;
      tick;
      chk("startstop.busy", busy, 0);
      chk("startstop.req", rd_mem_req, 0);

      // zero length treated as one
      start_run(20, 20, 0, 0);
      serve_line(1, 0, 0, 1, 0);

      // stop mid-line at row 5
      start_run(4, 7, 2, 0);
      serve_line(2, 0, 0, 0, 0);
      serve_line(2, 0, 1, 1, 0);
      repeat (4) tick;
      chk("stop5.req", rd_mem_req, 0);

      // randomized lines, first > last allowed
      pulse_clr;
      for (int run = 0; run < 4; run++) begin
         len = $urandom_range(1, 8);
         start_run($urandom_range(0, 5), $urandom_range(0, 5), len, $urandom_range(0, 1));
         for (int l = 0; l < 8; l++) begin
            r = $urandom_range(0, 4);
            nw = (r == 0) ? len + 1 : ((r == 1 && len > 1) ? len - 1 : len);
            mask = ($urandom_range(0, 2) == 0) ? int'($urandom() & 32'h1FF) : 0;
            serve_line(nw, mask, $urandom_range(0, 7), l == 7, 0);
         end
      end

      // screen counter wrap
      pulse_clr;
      start_run(9, 9, 1, 0);
      for (int l = 0; l < CNT_MAX + 2; l++) serve_line(1, 0, 0, l == CNT_MAX + 1, 0);
      chk("wrap.overrun", screen_cnt_overrun, 1);

      // fault counter saturation
      start_run(6, 6, 8, 0);
      serve_line(8, 32'hFF, 0, 0, 0);
      serve_line(8, 32'hFF, 0, 1, 0);
      chk("sat.fault_cnt", fault_cnt, CNT_MAX);

      // reset in the middle of a data burst
      start_run(2, 2, 4, 0);
      while (!rd_mem_req) tick;
      rd_mem_grant = 1'b1;
      tick;
      rd_mem_grant = 1'b0;
      rd_data = PAT;
      rd_data_valid = 1'b1;
      tick;
      rst = 1'b1;
      tick;
      rd_data_valid = 1'b0;
      model_clear;
      chk("midrst.req", rd_mem_req, 0);
      chk("midrst.busy", busy, 0);
      chk_status("midrst");
      rst = 1'b0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
